// File: rtl/alu_operand_issue.sv
// Operand-fetch/issue stage in front of the 32-bit ALU: register file, RAW scoreboard,
// write-back bypass and a single-entry issue register with valid/ready handshake.
module alu_operand_issue #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CTRLW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rs,
    input  logic [AW-1:0]    in_rt,
    input  logic [AW-1:0]    in_rd,
    input  logic             in_rd_we,
    input  logic [CTRLW-1:0] in_ctrl,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [DW-1:0]    wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    src1,
    output logic [DW-1:0]    src2,
    output logic [CTRLW-1:0] ALU_control,
    output logic [AW-1:0]    out_rd,
    output logic             out_rd_we
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;

    logic          wb_write;
    logic          wb_hit_rs;
    logic          wb_hit_rt;
    logic          hazard;
    logic          accept;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    assign wb_write  = wb_en && (wb_addr != '0);
    assign wb_hit_rs = wb_write && (wb_addr == in_rs);
    assign wb_hit_rt = wb_write && (wb_addr == in_rt);

    // A pending source is released in the very cycle its write-back arrives (bypass path).
    assign hazard   = (pending[in_rs] && !wb_hit_rs) || (pending[in_rt] && !wb_hit_rt);
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        rs_val = '0;
        if (in_rs != '0) begin
            rs_val = wb_hit_rs ? wb_data : regs[in_rs];
        end
    end

    always_comb begin
        rt_val = '0;
        if (in_rt != '0) begin
            rt_val = wb_hit_rt ? wb_data : regs[in_rt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Set is applied after clear so an issue to rd wins over a same-edge write-back to rd.
    always_comb begin
        pending_next = pending;
        if (wb_write) begin
            pending_next[wb_addr] = 1'b0;
        end
        if (accept && in_rd_we && (in_rd != '0)) begin
            pending_next[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            src1        <= '0;
            src2        <= '0;
            ALU_control <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            src1        <= rs_val;
            src2        <= rt_val;
            ALU_control <= in_ctrl;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
